// File: rtl/lockout_guard.sv
// ============================================================================
// Module      : lockout_guard
// Description : Gates enter/change pulses into the lock FSM, counts failed
//               attempts into a timed lockout and runs the auto-relock timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lockout_guard #(
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 50000000,
    parameter int OPEN_CYCLES = 250000000,
    parameter int CNT_W       = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enter_pulse,
    input  logic       change_pulse,
    input  logic       alarm_in,
    input  logic       open_in,
    output logic       enter_gated,
    output logic       change_gated,
    output logic       lockout,
    output logic       relock_req,
    output logic [3:0] fail_count
);

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_OPENED  = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    localparam logic [3:0]       c_max_fails = 4'(MAX_FAILS);
    localparam logic [CNT_W-1:0] c_lock_load = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_open_load = CNT_W'(OPEN_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    logic [3:0]       r_fail_count;
    logic [3:0]       w_fail_nxt;
    logic [3:0]       w_fail_inc;
    logic             r_alarm_q;
    logic             r_open_q;
    logic             r_lockout;
    logic             r_relock_req;
    logic             w_relock_nxt;
    logic             w_alarm_rise;
    logic             w_open_rise;
    logic             w_timer_zero;

    assign w_alarm_rise = alarm_in & ~r_alarm_q;
    assign w_open_rise  = open_in & ~r_open_q;
    assign w_timer_zero = (r_timer == '0);
    assign w_fail_inc   = (r_fail_count >= c_max_fails) ? r_fail_count
                                                        : r_fail_count + 4'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_fail_nxt   = r_fail_count;
        w_relock_nxt = 1'b0;
        case (r_state)
            ST_ARMED: begin
                if (w_alarm_rise) begin
                    w_fail_nxt = w_fail_inc;
                    if (w_fail_inc == c_max_fails) begin
                        w_state_nxt = ST_LOCKOUT;
                        w_timer_nxt = c_lock_load;
                    end
                end else if (w_open_rise) begin
                    w_fail_nxt  = 4'd0;
                    w_state_nxt = ST_OPENED;
                    w_timer_nxt = c_open_load;
                end
            end
            ST_OPENED: begin
                // A failure that completes the count abandons the relock timer.
                if (w_alarm_rise && (w_fail_inc == c_max_fails)) begin
                    w_fail_nxt  = w_fail_inc;
                    w_state_nxt = ST_LOCKOUT;
                    w_timer_nxt = c_lock_load;
                end else begin
                    if (w_alarm_rise) begin
                        w_fail_nxt = w_fail_inc;
                    end
                    if (!open_in) begin
                        w_state_nxt = ST_ARMED;
                    end else if (w_timer_zero) begin
                        w_relock_nxt = 1'b1;
                        w_state_nxt  = ST_ARMED;
                    end else begin
                        w_timer_nxt = r_timer - 1'b1;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (w_timer_zero) begin
                    w_state_nxt = ST_ARMED;
                    w_fail_nxt  = 4'd0;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_ARMED;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_ARMED;
            r_timer      <= '0;
            r_fail_count <= 4'd0;
            r_alarm_q    <= 1'b0;
            r_open_q     <= 1'b0;
            r_lockout    <= 1'b0;
            r_relock_req <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_fail_count <= w_fail_nxt;
            r_alarm_q    <= alarm_in;
            r_open_q     <= open_in;
            r_lockout    <= (w_state_nxt == ST_LOCKOUT);
            r_relock_req <= w_relock_nxt;
        end
    end

    // Pulses on the entry edge still pass; reset blocks them immediately.
    assign enter_gated  = enter_pulse  & (r_state != ST_LOCKOUT) & ~reset;
    assign change_gated = change_pulse & (r_state != ST_LOCKOUT) & ~reset;
    assign lockout      = r_lockout;
    assign relock_req   = r_relock_req;
    assign fail_count   = r_fail_count;

endmodule

`default_nettype wire

// File: tb/tb_lockout_guard.sv
// ============================================================================
// Module      : tb_lockout_guard
// Description : Scoreboard bench for lockout_guard against an event-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lockout_guard;

    localparam int MAXF  = 3;
    localparam int LOCKC = 10;
    localparam int OPENC = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       enter_pulse;
    logic       change_pulse;
    logic       alarm_in;
    logic       open_in;
    logic       enter_gated;
    logic       change_gated;
    logic       lockout;
    logic       relock_req;
    logic [3:0] fail_count;

    lockout_guard #(
        .MAX_FAILS  (MAXF),
        .LOCK_CYCLES(LOCKC),
        .OPEN_CYCLES(OPENC),
        .CNT_W      (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enter_pulse (enter_pulse),
        .change_pulse(change_pulse),
        .alarm_in    (alarm_in),
        .open_in     (open_in),
        .enter_gated (enter_gated),
        .change_gated(change_gated),
        .lockout     (lockout),
        .relock_req  (relock_req),
        .fail_count  (fail_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       eg;
        logic       cg;
        logic       lo;
        logic       rr;
        logic [3:0] fc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    // Model: failures so far, lockout cycles still to serve, open-session age.
    int m_fails;
    int m_lock_left;
    int m_open_age;
    bit m_open;
    bit m_relock;
    bit m_a_prev;
    bit m_o_prev;

    task automatic model_reset();
        m_fails     = 0;
        m_lock_left = 0;
        m_open_age  = 0;
        m_open      = 1'b0;
        m_relock    = 1'b0;
        m_a_prev    = 1'b0;
        m_o_prev    = 1'b0;
    endtask

    task automatic step(input bit r, input bit e, input bit c, input bit a, input bit o);
        exp_t x;
        bit   ra;
        bit   ro;
        @(posedge clock);
        #1;
        reset        = r;
        enter_pulse  = e;
        change_pulse = c;
        alarm_in     = a;
        open_in      = o;
        cyc++;
        if (r) begin
            x = '0;
            model_reset();
        end else begin
            x.eg = e && (m_lock_left == 0);
            x.cg = c && (m_lock_left == 0);
            x.lo = (m_lock_left > 0);
            x.rr = m_relock;
            x.fc = 4'(m_fails);
            ra = a && !m_a_prev;
            ro = o && !m_o_prev;
            m_relock = 1'b0;
            if (m_lock_left > 0) begin
                m_lock_left--;
                if (m_lock_left == 0) m_fails = 0;
            end else if (ra && (m_fails + 1 >= MAXF)) begin
                m_fails     = MAXF;
                m_lock_left = LOCKC;
                m_open      = 1'b0;
            end else begin
                if (ra) m_fails++;
                if (m_open) begin
                    if (!o) m_open = 1'b0;
                    else if (m_open_age == OPENC - 1) begin
                        m_relock = 1'b1;
                        m_open   = 1'b0;
                    end else m_open_age++;
                end else if (ro && !ra) begin
                    m_fails    = 0;
                    m_open     = 1'b1;
                    m_open_age = 0;
                end
            end
            m_a_prev = a;
            m_o_prev = o;
        end
        sb_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t x;
        exp_t act;
        forever begin
            @(negedge clock);
            if (sb_q.size() > 0) begin
                x   = sb_q.pop_front();
                act = {enter_gated, change_gated, lockout, relock_req, fail_count};
                checks++;
                if (act === x) passes++;
                else $display("FAIL outputs cyc=%0d got eg=%b cg=%b lo=%b rr=%b fc=%0d exp eg=%b cg=%b lo=%b rr=%b fc=%0d",
                              cyc, act.eg, act.cg, act.lo, act.rr, act.fc,
                              x.eg, x.cg, x.lo, x.rr, x.fc);
            end
        end
    end

    initial begin : stimulus
        bit a_st;
        bit o_st;
        reset = 1'b1; enter_pulse = 1'b0; change_pulse = 1'b0;
        alarm_in = 1'b0; open_in = 1'b0;
        model_reset();
        step(1, 1, 1, 1, 1);
        step(1, 0, 0, 0, 0);

        // Three spaced failures, then pulses every 3 cycles through lockout.
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 0);
            if (k < 2) idle(4);
        end
        for (int i = 0; i < 14; i++) step(0, i % 3 == 0, i % 3 == 0, 0, 0);

        // Level held high counts once.
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0);
        idle(2);

        // Two failures, then open held to relock; then open dropped early.
        step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
        idle(2);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        idle(12);

        // Alarm and open rise together with two failures pending.
        step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 1);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 1);
        idle(2);

        // Reset mid-lockout, then an enter pulse right after release.
        for (int k = 0; k < 3; k++) begin step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 0); end
        idle(3);
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        idle(2);

        // Randomized traffic with occasional resets.
        a_st = 1'b0;
        o_st = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (a_st) a_st = ($urandom_range(0, 2) == 0);
            else      a_st = ($urandom_range(0, 6) == 0);
            if (o_st) o_st = ($urandom_range(0, 11) != 0);
            else      o_st = ($urandom_range(0, 10) == 0);
            step($urandom_range(0, 399) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, a_st, o_st);
        end
        idle(2);
        @(posedge clock);
        @(posedge clock);
        checks++;
        if (sb_q.size() == 0) passes++;
        else $display("FAIL scoreboard_drain left=%0d required=0", sb_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lockout_guard.md
Name: lockout_guard

Overview:
- Sits between the enter/change input-conditioning stage and the Moore lock FSM.
- Gates the conditioned one-cycle enter/change pulses before they reach the FSM.
- Counts consecutive failed attempts, detected as rising edges of the FSM alarm output. After MAX_FAILS failures it imposes a timed lockout.
- While the FSM reports open, it runs an auto-relock timer and requests a relock on timeout.

Parameters:
MAX_FAILS, 3, consecutive failures that trigger lockout (range 1..15)
LOCK_CYCLES, 50000000, lockout duration in clock cycles (>=1)
OPEN_CYCLES, 250000000, cycles open_in may stay high before relock_req (>=1)
CNT_W, 32, timer width; must hold max(LOCK_CYCLES, OPEN_CYCLES)-1

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
enter_pulse  in  1  one-cycle conditioned enter pulse
change_pulse  in  1  one-cycle conditioned change pulse
alarm_in  in  1  FSM alarm level
open_in  in  1  FSM open level
enter_gated  out  1  enter pulse forwarded to FSM
change_gated  out  1  change pulse forwarded to FSM
lockout  out  1  high during lockout (registered)
relock_req  out  1  one-cycle pulse requesting FSM relock (registered)
fail_count  out  4  current consecutive-failure count (registered)

Behaviour:
- Reset (async, active-high):
  - state=ARMED, fail_count=0, timer=0.
  - alarm_q=0, open_q=0.
  - lockout=0, relock_req=0.
  - enter_gated and change_gated are 0 while reset is high.
- Edge detect:
  - alarm_q and open_q are registered copies of the inputs.
  - alarm_rise = alarm_in & ~alarm_q.
  - open_rise = open_in & ~open_q.
  - A level held high counts once.
- Gating:
  - enter_gated = enter_pulse & (state!=LOCKOUT); change_gated likewise.
  - Combinational, zero latency.
  - A pulse coincident with the LOCKOUT-entry edge still passes. A pulse in the cycle after entry is blocked.
- ARMED:
  - alarm_rise: fail_count+1. If the new value == MAX_FAILS -> LOCKOUT, timer=LOCK_CYCLES-1, lockout=1 from the next cycle.
  - open_rise (no alarm_rise): fail_count=0 -> OPENED, timer=OPEN_CYCLES-1.
  - Both edges in the same cycle: alarm wins; the open edge is ignored.
- OPENED:
  - timer decrements each cycle.
  - open_in falls before timer==0 -> ARMED, no relock_req.
  - timer==0 and open_in=1 -> relock_req=1 for exactly one cycle, then ARMED.
  - alarm_rise counts as a failure with the same rules as ARMED. It may enter LOCKOUT directly; the relock timer is abandoned.
- LOCKOUT:
  - alarm/open edges ignored; edge registers keep tracking.
  - timer decrements.
  - At timer==0: -> ARMED, fail_count=0, lockout=0 next cycle.
  - Total lockout high time = LOCK_CYCLES cycles.
- fail_count:
  - Saturates at MAX_FAILS; never wraps.
  - Cleared only by open_rise, lockout expiry or reset.
- Timer:
  - Unsigned CNT_W down-counter; never decrements below 0.
  - Idle (held) in ARMED.
- Reset mid-lockout or mid-open: immediate return to reset values; no relock_req emitted.
- Illegal state encoding: recovers to ARMED.

Test Plan (MAX_FAILS=3, LOCK_CYCLES=10, OPEN_CYCLES=8):
1. Three alarm_in pulses 1 cycle high, 5 cycles apart -> fail_count 1,2,3. lockout rises the cycle after the 3rd edge, stays high exactly 10 cycles, then fail_count=0.
2. During lockout, drive enter_pulse and change_pulse every 3 cycles -> enter_gated and change_gated stay 0. The first pulse after lockout falls passes through same cycle.
3. Two failures, then open_in high -> fail_count=0, then relock_req single-cycle pulse 8 cycles after the open edge. Drop open_in at cycle 4 instead -> no relock_req.
4. alarm_in and open_in rise in same cycle with fail_count=2 -> LOCKOUT entered, no OPENED, fail_count=3.
5. alarm_in held high 20 cycles -> fail_count increments once only.
6. Assert reset asynchronously mid-lockout (timer=5) -> lockout, fail_count, relock_req drop to 0 without a clock edge. After release, an enter_pulse passes immediately.
